ins_mem_fetch: RTL and testbench

//  Parametrised, loadable instruction memory with a fetch handshake; the next generation of the CPU's read-only instruction store.

---
 rtl/ins_mem_pkg.sv | 20 ++
 rtl/ins_mem_array.sv | 31 +++
 rtl/ins_mem_fetch.sv | 156 +++++++++++++++
 tb/tb_ins_mem_fetch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_mem_pkg.sv
// Shared types and defaults for the loadable instruction memory.
// Optional build macro used by this slice: INS_MEM_PARITY_EN (per-word even parity).
package ins_mem_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } state_e;

  // The implemented depth may be smaller than the address space, so range checks
  // are done in 32-bit arithmetic rather than in ADDR_W bits.
  function automatic logic addr_in_range(input int unsigned addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/ins_mem_array.sv
// 1R1W synchronous RAM with a registered read port and no reset on the storage.
// The read register only updates on rd_en, so the last fetched word is held between reads.
module ins_mem_array #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/ins_mem_fetch.sv
// Instruction store with a sequential program-load port and valid/ready fetch/response handshakes.
// Build macro INS_MEM_PARITY_EN adds a stored even-parity bit per word, checked on every fetch.
module ins_mem_fetch
  import ins_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  input  logic              resp_ready,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              ld_err,
  output logic              busy
);

`ifdef INS_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e            state_q;
  logic [ADDR_W-1:0] ptr_q;
  logic              ld_ready_q;
  logic              busy_q;
  logic              ld_err_q;
  logic              resp_valid_q;
  logic              oor_q;

  logic              req_fire;
  logic              ld_fire;
  logic              req_in_range;
  logic              base_in_range;
  logic [ADDR_W-1:0] ptr_inc;
  logic [MEM_W-1:0]  wr_word;
  logic [MEM_W-1:0]  rd_word;
  logic              par_err;

  assign req_in_range  = addr_in_range(32'(req_addr), DEPTH);
  assign base_in_range = addr_in_range(32'(ld_base), DEPTH);

  // A pending ld_start blocks fetch acceptance so the load always wins the cycle.
  assign req_ready = (state_q == ST_RUN) & ~ld_start & (~resp_valid_q | resp_ready);
  assign req_fire  = req_valid & req_ready;
  assign ld_fire   = ld_valid & ld_ready_q;

  // Load pointer wraps at the implemented depth, not at the address-space size.
  assign ptr_inc = (32'(ptr_q) == DEPTH - 1) ? '0 : ptr_q + ADDR_W'(1);

`ifdef INS_MEM_PARITY_EN
  assign wr_word = {^ld_data, ld_data};
  assign par_err = ^rd_word;
`else
  assign wr_word = ld_data;
  assign par_err = 1'b0;
`endif

  ins_mem_array #(
    .WIDTH  (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_fire),
    .wr_addr (ptr_q),
    .wr_data (wr_word),
    .rd_en   (req_fire & req_in_range),
    .rd_addr (req_addr),
    .rd_data (rd_word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_RUN;
      ptr_q      <= '0;
      ld_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      ld_err_q <= 1'b0;
      case (state_q)
        ST_RUN: begin
          if (ld_start) begin
            if (base_in_range) begin
              ptr_q  <= ld_base;
              busy_q <= 1'b1;
              if (resp_valid_q) begin
                state_q <= ST_DRAIN;
              end else begin
                state_q    <= ST_LOAD;
                ld_ready_q <= 1'b1;
              end
            end else begin
              ld_err_q <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (~resp_valid_q | resp_ready) begin
            state_q    <= ST_LOAD;
            ld_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_fire) begin
            ptr_q <= ptr_inc;
            if (ld_last) begin
              state_q    <= ST_RUN;
              ld_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q    <= ST_RUN;
          ld_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  // The RAM read register carries the response word; this tracks its validity and range flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      oor_q        <= 1'b0;
    end else if (req_fire) begin
      resp_valid_q <= 1'b1;
      oor_q        <= ~req_in_range;
    end else if (resp_ready) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_data  = (resp_valid_q & ~oor_q) ? rd_word[DATA_W-1:0] : '0;
  assign resp_err   = resp_valid_q & (oor_q | par_err);
  assign ld_ready   = ld_ready_q;
  assign ld_err     = ld_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ins_mem_fetch.sv
// Directed self-checking bench for ins_mem_fetch with DEPTH=200 (exercises the pointer wrap and range flags).
module tb_ins_mem_fetch;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;
  logic              resp_ready;
  logic              ld_start;
  logic [ADDR_W-1:0] ld_base;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              ld_err;
  logic              busy;

  int n_total = 0;
  int n_pass  = 0;

  ins_mem_fetch #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .resp_ready (resp_ready),
    .ld_start   (ld_start),
    .ld_base    (ld_base),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_err     (ld_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input string tag, input logic [ADDR_W-1:0] base, input int n,
                         input logic [3:0][DATA_W-1:0] w);
    int waited;
    waited   = 0;
    ld_start = 1'b1;
    ld_base  = base;
    tick();
    ld_start = 1'b0;
    while (!ld_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = w[i];
      ld_last  = (i == n - 1);
      tick();
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check({tag, "_busy_done"}, 32'(busy), 32'd0);
  endtask

  task automatic fetch1(input string tag, input logic [ADDR_W-1:0] a,
                        input logic [DATA_W-1:0] d, input logic e);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    req_addr   = a;
    tick();
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(resp_valid), 32'd1);
    check({tag, "_data"}, 32'(resp_data), 32'(d));
    check({tag, "_err"}, 32'(resp_err), 32'(e));
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0][DATA_W-1:0] words;
    logic [3:0][DATA_W-1:0] exp_seq;

    rst = 1'b1; req_valid = 1'b0; req_addr = '0; resp_ready = 1'b0;
    ld_start = 1'b0; ld_base = '0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick();
    tick();
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd0);
    check("rst_ld_err", 32'(ld_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: load 4 words at 0x10, then stream them back one per cycle.
    words = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    do_load("t1", 8'h10, 4, words);
    resp_ready = 1'b1;
    req_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr = 8'h10 + 8'(i);
      #1;
      check($sformatf("t1_req_ready_%0d", i), 32'(req_ready), 32'd1);
      tick();
      check($sformatf("t1_valid_%0d", i), 32'(resp_valid), 32'd1);
      check($sformatf("t1_data_%0d", i), 32'(resp_data), 32'(words[i]));
    end
    req_valid = 1'b0;
    tick();
    check("t1_valid_drop", 32'(resp_valid), 32'd0);

    // Test 2: response held stable under back-pressure.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 8'h10;
    tick();
    req_addr = 8'h11;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_req_ready_%0d", i), 32'(req_ready), 32'd0);
      tick();
      check($sformatf("t2_valid_%0d", i), 32'(resp_valid), 32'd1);
      check($sformatf("t2_data_%0d", i), 32'(resp_data), 32'h1111);
    end
    resp_ready = 1'b1;
    #1;
    check("t2_req_ready_release", 32'(req_ready), 32'd1);
    tick();
    check("t2_next_data", 32'(resp_data), 32'h2222);
    req_valid = 1'b0;
    tick();
    check("t2_valid_drop", 32'(resp_valid), 32'd0);

    // Test 3: pointer wraps at DEPTH-1 -> 0; address 200 is out of range.
    words = {16'h0000, 16'hCCCC, 16'hBBBB, 16'hAAAA};
    do_load("t3", 8'd199, 3, words);
    fetch1("t3_a199", 8'd199, 16'hAAAA, 1'b0);
    fetch1("t3_a0", 8'd0, 16'hBBBB, 1'b0);
    fetch1("t3_a1", 8'd1, 16'hCCCC, 1'b0);
    fetch1("t3_a200", 8'd200, 16'h0000, 1'b1);
    fetch1("t3_after_oor", 8'h12, 16'h3333, 1'b0);

    // Test 4: ld_start with a pending, unaccepted response goes through DRAIN.
    resp_ready = 1'b0;
    req_valid  = 1'b1;
    req_addr   = 8'h11;
    tick();
    req_valid = 1'b0;
    check("t4_pending_data", 32'(resp_data), 32'h2222);
    ld_start = 1'b1;
    ld_base  = 8'h20;
    #1;
    check("t4_req_ready_ldstart", 32'(req_ready), 32'd0);
    tick();
    ld_start = 1'b0;
    check("t4_drain_busy", 32'(busy), 32'd1);
    check("t4_drain_ld_ready", 32'(ld_ready), 32'd0);
    check("t4_drain_resp_held", 32'(resp_data), 32'h2222);
    tick();
    check("t4_drain_ld_ready2", 32'(ld_ready), 32'd0);
    resp_ready = 1'b1;
    tick();
    check("t4_load_ld_ready", 32'(ld_ready), 32'd1);
    check("t4_load_resp_valid", 32'(resp_valid), 32'd0);
    ld_valid = 1'b1;
    ld_data  = 16'h5555;
    ld_last  = 1'b1;
    tick();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    check("t4_back_to_run", 32'(busy), 32'd0);
    fetch1("t4_a20", 8'h20, 16'h5555, 1'b0);

    // Out-of-range load base with a simultaneous fetch: error pulse, fetch not accepted.
    req_valid = 1'b1;
    req_addr  = 8'h10;
    ld_start  = 1'b1;
    ld_base   = 8'd250;
    #1;
    check("t4_ldstart_blocks_req", 32'(req_ready), 32'd0);
    tick();
    ld_start  = 1'b0;
    req_valid = 1'b0;
    check("t4_ld_err_pulse", 32'(ld_err), 32'd1);
    check("t4_ld_err_busy", 32'(busy), 32'd0);
    check("t4_ld_err_no_fetch", 32'(resp_valid), 32'd0);
    tick();
    check("t4_ld_err_clear", 32'(ld_err), 32'd0);

    // Test 5: reset in the middle of a burst keeps the words already written.
    words = {16'h0404, 16'h0303, 16'h0202, 16'h0101};
    do_load("t5_pre", 8'h30, 4, words);
    ld_start = 1'b1;
    ld_base  = 8'h30;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_data  = 16'hE1E1;
    tick();
    ld_data = 16'hE2E2;
    tick();
    ld_data = 16'hE3E3;
    rst     = 1'b1;
    #1;
    check("t5_rst_ld_ready", 32'(ld_ready), 32'd0);
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_resp_valid", 32'(resp_valid), 32'd0);
    check("t5_rst_ld_err", 32'(ld_err), 32'd0);
    ld_valid = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    exp_seq = {16'h0404, 16'h0303, 16'hE2E2, 16'hE1E1};
    for (int i = 0; i < 4; i++) begin
      fetch1($sformatf("t5_a%0d", i), 8'h30 + 8'(i), exp_seq[i], 1'b0);
    end

`ifdef INS_MEM_PARITY_EN
    // Test 6: a corrupted stored bit is flagged and the raw word is still returned.
    dut.u_array.mem_q[8'h10][0] = ~dut.u_array.mem_q[8'h10][0];
    fetch1("t6_parity", 8'h10, 16'h1110, 1'b1);
    fetch1("t6_clean", 8'h11, 16'h2222, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
